// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, moves and retires up to four obstacles per game tick and raises speed every eight retirements
module obstacle_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int X_SPAWN = 800,
  parameter int X_RETIRE = 150,
  parameter int SPEED_MIN = 6,
  parameter int SPEED_MAX = 15,
  parameter int GAP_MIN = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    clear,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [4:0]              speed,
  output logic                    spawn_pulse,
  output logic                    level_up
);
  logic [15:0] lfsr_q, lfsr_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d, free_oh;
  logic [9:0] x_q [NUM_SLOTS];
  logic [9:0] x_d [NUM_SLOTS];
  logic [4:0] speed_q, speed_d;
  logic [7:0] gap_q, gap_d;
  logic [2:0] retire_q, retire_d, n_ret;
  logic [3:0] sum;
  logic spawn_q, spawn_d, level_q, level_d;
  // lowest-index free slot as a one-hot, taken from pre-tick validity so a slot retired this tick stays unused
  assign free_oh = ~valid_q & (valid_q + 1'b1);
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    valid_d = valid_q;
    x_d = x_q;
    speed_d = speed_q;
    gap_d = gap_q;
    retire_d = retire_q;
    spawn_d = 1'b0;
    level_d = 1'b0;
    n_ret = '0;
    sum = '0;
    if (clear) begin
      valid_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) x_d[i] = '0;
      speed_d = 5'(SPEED_MIN);
      gap_d = 8'(GAP_MIN);
      retire_d = '0;
    end else if (tick && run) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valid_q[i] && x_q[i] > 10'(X_RETIRE)) x_d[i] = x_q[i] - 10'(speed_q);
        if (valid_q[i] && x_q[i] <= 10'(X_RETIRE)) begin
          valid_d[i] = 1'b0;
          x_d[i] = '0;
          n_ret = n_ret + 3'd1;
        end
      end
      if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
      else if (|free_oh) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (free_oh[i]) begin
            valid_d[i] = 1'b1;
            x_d[i] = 10'(X_SPAWN);
          end
        end
        gap_d = 8'(GAP_MIN) + {2'b00, lfsr_q[5:0]};
        spawn_d = 1'b1;
      end
      sum = {1'b0, retire_q} + {1'b0, n_ret};
      retire_d = sum[2:0];
      level_d = sum[3];
      if (sum[3]) speed_d = (speed_q == 5'(SPEED_MAX)) ? 5'(SPEED_MIN) : speed_q + 5'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
      valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) x_q[i] <= '0;
      speed_q <= 5'(SPEED_MIN);
      gap_q <= 8'(GAP_MIN);
      retire_q <= '0;
      spawn_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      valid_q <= valid_d;
      x_q <= x_d;
      speed_q <= speed_d;
      gap_q <= gap_d;
      retire_q <= retire_d;
      spawn_q <= spawn_d;
      level_q <= level_d;
    end
  end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_x
    assign slot_x[10*g +: 10] = x_q[g];
  end
  assign slot_valid = valid_q;
  assign speed = speed_q;
  assign spawn_pulse = spawn_q;
  assign level_up = level_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed scenarios plus a long randomized run checked against a behavioural game model
module tb_obstacle_scheduler;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, run = 1'b0, clear = 1'b0;
  logic [3:0] slot_valid;
  logic [39:0] slot_x;
  logic [4:0] speed;
  logic spawn_pulse, level_up;
  int checks = 0, passed = 0;
  int mv[4], mx[4], msp, mgap, mrc, mlfsr, mspawn, mlvl;

  obstacle_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear),
    .slot_valid(slot_valid), .slot_x(slot_x), .speed(speed),
    .spawn_pulse(spawn_pulse), .level_up(level_up)
  );

  always #5 clk = ~clk;

  task automatic model_restart(input bit keep_lfsr);
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0;
      mx[i] = 0;
    end
    msp = 6; mgap = 20; mrc = 0; mspawn = 0; mlvl = 0;
    if (!keep_lfsr) mlfsr = 'hACE1;
  endtask

  task automatic model_step(input bit r, input bit t, input bit rn, input bit c);
    int old_lfsr, ret, fs;
    old_lfsr = mlfsr;
    mlfsr = (mlfsr >> 1) ^ ((mlfsr % 2 == 1) ? 'hB400 : 0);
    if (!r) model_restart(0);
    else if (c) model_restart(1);
    else if (t && rn) begin
      ret = 0;
      fs = -1;
      for (int i = 0; i < 4; i++) if (mv[i] == 0 && fs < 0) fs = i;
      for (int i = 0; i < 4; i++)
        if (mv[i] == 1) begin
          if (mx[i] > 150) mx[i] -= msp;
          else begin
            mv[i] = 0;
            mx[i] = 0;
            ret++;
          end
        end
      mspawn = 0;
      if (mgap > 0) mgap--;
      else if (fs >= 0) begin
        mv[fs] = 1;
        mx[fs] = 800;
        mgap = 20 + old_lfsr % 64;
        mspawn = 1;
      end
      mrc += ret;
      mlvl = 0;
      if (mrc >= 8) begin
        mrc -= 8;
        mlvl = 1;
        msp = (msp == 15) ? 6 : msp + 1;
      end
    end else begin
      mspawn = 0;
      mlvl = 0;
    end
  endtask

  function automatic logic [3:0] exp_valid();
    for (int i = 0; i < 4; i++) exp_valid[i] = (mv[i] == 1);
  endfunction

  function automatic logic [39:0] exp_x();
    for (int i = 0; i < 4; i++) exp_x[10*i +: 10] = 10'(mx[i]);
  endfunction

  task automatic cyc(input bit r, input bit t, input bit rn, input bit c);
    @(negedge clk);
    rst = r; tick = t; run = rn; clear = c;
    @(posedge clk);
    model_step(r, t, rn, c);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 0);
    checks++;
    if (slot_valid !== 4'b0 || speed !== 5'd6 || spawn_pulse !== 1'b0 || level_up !== 1'b0 || slot_x !== 40'd0)
      $display("FAIL reset: valid=%b speed=%0d spawn=%b lvl=%b x=%h, want 0/6/0/0/0", slot_valid, speed, spawn_pulse, level_up, slot_x);
    else passed++;
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0);
    checks++;
    if (slot_valid !== 4'b0 || spawn_pulse !== 1'b0)
      $display("FAIL gap_20: valid=%b spawn=%b, want 0000/0", slot_valid, spawn_pulse);
    else passed++;
    cyc(1, 1, 1, 0);
    checks++;
    if (slot_valid !== 4'b0001 || slot_x[9:0] !== 10'd800 || spawn_pulse !== 1'b1)
      $display("FAIL first_spawn: valid=%b x0=%0d spawn=%b, want 0001/800/1", slot_valid, slot_x[9:0], spawn_pulse);
    else passed++;
    cyc(1, 1, 1, 0);
    checks++;
    if (spawn_pulse !== 1'b0 || slot_x[9:0] !== 10'd794)
      $display("FAIL spawn_pulse_once: spawn=%b x0=%0d, want 0/794", spawn_pulse, slot_x[9:0]);
    else passed++;
  endtask

  task automatic test_motion;
    for (int i = 0; i < 107; i++) begin
      cyc(1, 1, 1, 0);
      checks++;
      if (slot_valid !== exp_valid() || slot_x !== exp_x() || spawn_pulse !== 1'(mspawn))
        $display("FAIL motion_track: valid=%b x=%h spawn=%b, want %b %h %0d", slot_valid, slot_x, spawn_pulse, exp_valid(), exp_x(), mspawn);
      else passed++;
    end
    checks++;
    if (slot_x[9:0] !== 10'd152 || slot_valid[0] !== 1'b1)
      $display("FAIL motion_152: x0=%0d v0=%b, want 152/1", slot_x[9:0], slot_valid[0]);
    else passed++;
    cyc(1, 1, 1, 0);
    checks++;
    if (slot_x[9:0] !== 10'd146 || slot_valid[0] !== 1'b1)
      $display("FAIL motion_146: x0=%0d v0=%b, want 146/1", slot_x[9:0], slot_valid[0]);
    else passed++;
    cyc(1, 1, 1, 0);
    checks++;
    if (slot_valid[0] !== 1'b0 || slot_x[9:0] !== 10'd0)
      $display("FAIL retire: v0=%b x0=%0d, want 0/0", slot_valid[0], slot_x[9:0]);
    else passed++;
  endtask

  task automatic test_freeze;
    logic [39:0] snap;
    snap = exp_x();
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 0, 0);
      checks++;
      if (slot_x !== snap || slot_valid !== exp_valid() || spawn_pulse !== 1'b0 || level_up !== 1'b0)
        $display("FAIL freeze: x=%h valid=%b spawn=%b lvl=%b, want %h %b 0 0", slot_x, slot_valid, spawn_pulse, level_up, snap, exp_valid());
      else passed++;
    end
  endtask

  task automatic test_clear_priority;
    cyc(1, 1, 1, 1);
    checks++;
    if (slot_valid !== 4'b0 || slot_x !== 40'd0 || speed !== 5'd6 || spawn_pulse !== 1'b0 || level_up !== 1'b0)
      $display("FAIL clear_tick: valid=%b x=%h speed=%0d spawn=%b lvl=%b, want 0/0/6/0/0", slot_valid, slot_x, speed, spawn_pulse, level_up);
    else passed++;
    for (int i = 0; i < 21; i++) cyc(1, 1, 1, 0);
    checks++;
    if (slot_valid !== 4'b0001 || spawn_pulse !== 1'b1 || slot_x[9:0] !== 10'd800)
      $display("FAIL clear_respawn: valid=%b spawn=%b x0=%0d, want 0001/1/800", slot_valid, spawn_pulse, slot_x[9:0]);
    else passed++;
  endtask

  task automatic test_random_run;
    int fails = 0;
    bit wrap_seen = 0, full_seen = 0;
    logic [4:0] prev_speed;
    for (int n = 0; n < 30000; n++) begin
      prev_speed = speed;
      cyc(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0), 0);
      checks++;
      if (slot_valid !== exp_valid() || slot_x !== exp_x() || speed !== 5'(msp) ||
          spawn_pulse !== 1'(mspawn) || level_up !== 1'(mlvl)) begin
        if (fails < 10)
          $display("FAIL random_run cyc %0d: valid=%b x=%h speed=%0d spawn=%b lvl=%b, want %b %h %0d %0d %0d",
                   n, slot_valid, slot_x, speed, spawn_pulse, level_up, exp_valid(), exp_x(), msp, mspawn, mlvl);
        fails++;
      end else passed++;
      if (prev_speed == 5'd15 && speed == 5'd6 && level_up) wrap_seen = 1;
      if (slot_valid == 4'b1111) full_seen = 1;
    end
    checks++;
    if (!wrap_seen) $display("FAIL speed_wrap: seen=%0d, want 1", wrap_seen);
    else passed++;
    checks++;
    if (!full_seen) $display("FAIL all_slots_full: seen=%0d, want 1", full_seen);
    else passed++;
  endtask

  initial begin
    model_restart(0);
    test_reset;
    test_motion;
    test_freeze;
    test_clear_priority;
    test_random_run;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Sequences the horizontal obstacle datapath for the dinosaur game. It owns up to four obstacle slots and spawns new obstacles after pseudo-random gaps from a 16-bit LFSR. On each game tick it advances every live obstacle by the current speed, retires obstacles that reach the left edge, and raises the speed level after every eight retirements. It sits between the game state machine, which supplies `run` and `clear`, and the pixel/collision logic, which consumes the slot positions.

## Interface
- `NUM_SLOTS`, 4: number of obstacle slots; legal values 1–4.
- `X_SPAWN`, 800: x position loaded into a newly spawned slot (10 bits).
- `X_RETIRE`, 150: a slot whose x is ≤ this value at a tick is retired; must be ≥ `SPEED_MAX`.
- `SPEED_MIN`, 6: reset speed and wrap target (5 bits).
- `SPEED_MAX`, 15: highest speed; the step after this wraps to `SPEED_MIN`.
- `GAP_MIN`, 20: minimum number of ticks between spawns.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: game clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `tick` in 1: one-cycle strobe per game frame step.
- `run` in 1: high while the game is in its play state; gates `tick`.
- `clear` in 1: synchronous restart pulse from the game-init state.
- `slot_valid` out `NUM_SLOTS`: bit i high means slot i holds a live obstacle.
- `slot_x` out 10×`NUM_SLOTS`: packed x centres; slot i occupies bits [10i+9:10i]. Don't-care when the slot is invalid; driven to 0.
- `speed` out 5: current pixels-per-tick.
- `spawn_pulse` out 1: high for one cycle after a spawn.
- `level_up` out 1: high for one cycle after a speed change.

## Operation
- Priority, highest first: reset (`rst`=0), then `clear`, then an active tick (`tick`&`run`), then hold.
- **Reset** loads the following, and all outputs reflect these values on the cycle after:
  - `slot_valid`=0, all `slot_x`=0
  - `speed`=`SPEED_MIN`, `gap_cnt`=`GAP_MIN`, `retire_cnt`=0
  - `lfsr`=`LFSR_SEED`
  - `spawn_pulse`=0, `level_up`=0
- **Clear** does the same as reset, except the LFSR keeps running.
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (shift right; XOR mask 16'hB400 when the LSB is 1). Advances every clock cycle regardless of `tick`, `run` or `clear`; only reset reloads it.
- **Active tick.** All of the following are evaluated from pre-tick register values:
  - **Move:** each valid slot with x > `X_RETIRE` takes x ← x − `speed`.
  - **Retire:** each valid slot with x ≤ `X_RETIRE` takes valid ← 0 and x ← 0.
  - **Gap:** if `gap_cnt` > 0, it decrements.
  - **Spawn:** if `gap_cnt` = 0 and at least one slot is invalid before this tick:
    - the lowest-index invalid slot gets valid ← 1 and x ← `X_SPAWN`;
    - `gap_cnt` ← `GAP_MIN` + `lfsr[5:0]`;
    - `spawn_pulse` ← 1.
  - If `gap_cnt` = 0 and every slot is valid, `gap_cnt` holds at 0 and the spawn waits for a later tick.
  - A slot retired on this tick is not reusable until the next tick. A newly spawned slot is not moved on its spawn tick.
- **Level.** `retire_cnt` is 3 bits. On each active tick, add the number of slots retired that tick. If the 4-bit sum is ≥ 8, a level step occurs:
  - `level_up` ← 1;
  - `speed` ← `speed`+1, or `SPEED_MIN` if `speed` = `SPEED_MAX`.
  - At most one level step per tick; `retire_cnt` keeps the sum mod 8.
- `tick` while `run`=0: no change to any state except the LFSR.
- All arithmetic is unsigned. x never underflows, because `X_RETIRE` ≥ `SPEED_MAX`. Gap width: 6-bit random term plus `GAP_MIN`, in an 8-bit counter.

## Timing
- All outputs are registered.
- An active tick sampled at edge n is reflected on `slot_valid`, `slot_x`, `speed`, `spawn_pulse` and `level_up` after edge n; latency is 1 cycle.
- `spawn_pulse` and `level_up` are high for exactly the one cycle after the tick that caused them, then return to 0. They are never stretched, even if `tick` is held high.
- `tick` held high for k cycles counts as k ticks. Back-to-back ticks are legal.
- Reset or `clear` in the middle of a tick cycle wins; the tick's effects are discarded.
- Downstream collision logic must sample `slot_x` no earlier than one cycle after `tick`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, release → `slot_valid`=0, `speed`=6, `spawn_pulse`=0. After 21 active ticks, the first spawn lands in slot 0 at x=800.
- **Motion/retire:** one obstacle at 800 with `speed`=6 → after 108 further ticks x=152; the next tick gives x=146; the tick after clears `slot_valid[0]`.
- **Slot allocation:** force a long run at `GAP_MIN`=1 → spawns fill slots 0,1,2,3 in order. With all four valid, `gap_cnt` sticks at 0. When slot 1 retires, the next tick spawns into slot 1.
- **Level wrap:** drive 8 retirements → `level_up` is high for one cycle and `speed`=7. Repeat until `speed`=15; the next 8 retirements give `speed`=6.
- **Simultaneous retire:** two slots retire on one tick with `retire_cnt`=7 → exactly one level step, `retire_cnt`=1.
- **Freeze/clear priority:** `run`=0 with `tick` pulses → positions frozen while the LFSR still changes. `clear` and `tick` in the same cycle → reset values, no `spawn_pulse`.
